// File: rtl/us_drv_pkg.sv
// Shared definitions for the phased ultrasonic driver: register map, run mode and FSM state encodings.
package us_drv_pkg;

  localparam logic [7:0] ADDR_PERIOD  = 8'd0;
  localparam logic [7:0] ADDR_DEAD    = 8'd1;
  localparam logic [7:0] ADDR_BURST   = 8'd2;
  localparam logic [7:0] ADDR_MODE    = 8'd3;
  localparam logic [7:0] ADDR_CHEN    = 8'd4;
  localparam logic [7:0] ADDR_CH_BASE = 8'd8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_CONT  = 2'd1,
    MODE_BURST = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BURST
  } state_e;

endpackage

// File: rtl/us_drv_channel.sv
// One driver channel: phase-shifted compare against the shared counter, then dead-time
// insertion and the registered complementary a/b outputs.
module us_drv_channel #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DEAD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              en,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  phase,
  input  logic [CNT_W-1:0]  duty,
  input  logic [DEAD_W-1:0] dead,
  output logic              ch_a,
  output logic              ch_b
);

  logic [CNT_W:0]  sum;
  logic [CNT_W:0]  pos;
  logic            raw;
  logic            raw_q;
  logic [DEAD_W-1:0] dcnt;
  logic [DEAD_W-1:0] dcnt_n;
  logic            drive;

  always_comb begin
    sum = {1'b0, cnt} + {1'b0, phase};
    pos = (sum >= {1'b0, period}) ? sum - {1'b0, period} : sum;
    raw = run && en && (pos < {1'b0, duty});
    // Any edge of raw, including the first after IDLE, opens a dead-time gap
    if (raw != raw_q)
      dcnt_n = dead;
    else if (dcnt != '0)
      dcnt_n = dcnt - DEAD_W'(1);
    else
      dcnt_n = '0;
    drive = run && en && (dcnt_n == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= 1'b0;
      dcnt  <= '0;
      ch_a  <= 1'b0;
      ch_b  <= 1'b0;
    end else begin
      raw_q <= raw;
      dcnt  <= dcnt_n;
      ch_a  <= drive && raw;
      ch_b  <= drive && !raw;
    end
  end

endmodule

// File: rtl/us_phased_driver.sv
// Multi-channel phased ultrasonic driver: shadow/active config, shared period counter,
// continuous/burst FSM, and one us_drv_channel per output pair.
module us_phased_driver
  import us_drv_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEAD_W     = 4,
  parameter int unsigned DEF_PERIOD = 675
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              period_tick,
  output logic [NUM_CH-1:0] ch_a,
  output logic [NUM_CH-1:0] ch_b
);

  logic [CNT_W-1:0]  period_s, period_a;
  logic [DEAD_W-1:0] dead_s, dead_a;
  logic [CNT_W-1:0]  burst_s;
  logic [1:0]        mode_s;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  bcnt;
  logic              stop_l;
  logic              running;
  logic              wrap;
  logic              commit;
  state_e            state, state_n;

  assign running     = (state != ST_IDLE);
  assign wrap        = running && (cnt == period_a - CNT_W'(1));
  assign commit      = !running || wrap;
  assign busy        = running;
  assign period_tick = wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_s <= CNT_W'(DEF_PERIOD);
      dead_s   <= '0;
      burst_s  <= CNT_W'(1);
      mode_s   <= MODE_CONT;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_PERIOD: period_s <= (cfg_wdata < CNT_W'(2)) ? CNT_W'(2) : cfg_wdata;
        ADDR_DEAD:   dead_s   <= cfg_wdata[DEAD_W-1:0];
        ADDR_BURST:  burst_s  <= cfg_wdata;
        ADDR_MODE:   mode_s   <= cfg_wdata[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_a <= CNT_W'(DEF_PERIOD);
      dead_a   <= '0;
    end else if (commit) begin
      period_a <= period_s;
      dead_a   <= dead_s;
    end
  end

  // Start decisions read the shadow copy so a mode write is usable on the next cycle
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (mode_s == MODE_CONT)
            state_n = ST_RUN;
          else if (mode_s == MODE_BURST && burst_s != '0)
            state_n = ST_BURST;
        end
      end
      ST_RUN:   if (wrap && (stop_l || stop)) state_n = ST_IDLE;
      ST_BURST: if (wrap && (stop_l || stop || bcnt == '0)) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      stop_l <= 1'b0;
      bcnt   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= commit ? '0 : cnt + CNT_W'(1);
      stop_l <= running && (stop_l || stop);
      if (!running)
        bcnt <= burst_s - CNT_W'(1);
      else if (state == ST_BURST && wrap && bcnt != '0)
        bcnt <= bcnt - CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [7:0] A_PH = ADDR_CH_BASE + 8'(2 * g);
    localparam logic [7:0] A_DU = A_PH + 8'd1;

    logic [CNT_W-1:0] phase_s, duty_s, phase_a, duty_a;
    logic             en_s, en_a;

    always_ff @(posedge clk) begin
      if (rst) begin
        phase_s <= '0;
        duty_s  <= CNT_W'(DEF_PERIOD / 2);
        en_s    <= 1'b1;
      end else if (cfg_we) begin
        if (cfg_addr == A_PH) phase_s <= cfg_wdata;
        if (cfg_addr == A_DU) duty_s  <= cfg_wdata;
        if (cfg_addr == ADDR_CHEN) en_s <= (g < CNT_W) ? cfg_wdata[g % CNT_W] : 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        phase_a <= '0;
        duty_a  <= CNT_W'(DEF_PERIOD / 2);
        en_a    <= 1'b1;
      end else if (commit) begin
        phase_a <= (phase_s >= period_s) ? period_s - CNT_W'(1) : phase_s;
        duty_a  <= duty_s;
        en_a    <= en_s;
      end
    end

    us_drv_channel #(
      .CNT_W (CNT_W),
      .DEAD_W(DEAD_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .run   (running),
      .en    (en_a),
      .cnt   (cnt),
      .period(period_a),
      .phase (phase_a),
      .duty  (duty_a),
      .dead  (dead_a),
      .ch_a  (ch_a[g]),
      .ch_b  (ch_b[g])
    );
  end

endmodule
